// File: rtl/sram_pixel_writer.sv
// Packs a stream of 24-bit RGB pixels into 16-bit SRAM words, two pixels per
// three words ({R0,G0}, {B0,R1}, {G1,B1}), for one frame at contiguous addresses.
module sram_pixel_writer #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [17:0] i_base_address,
    input  logic        i_pixel_valid,
    output logic        o_pixel_ready,
    input  logic [23:0] i_pixel_data,
    output logic [17:0] o_sram_address,
    output logic [15:0] o_sram_write_data,
    output logic        o_sram_we_n,
    output logic        o_busy,
    output logic        o_done,
    output logic [9:0]  o_pixel_col,
    output logic [9:0]  o_pixel_row,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EVEN  = 3'd1,
        S_ODD   = 3'd2,
        S_ODD_2 = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [9:0] LAST_COL = 10'(IMAGE_WIDTH - 1);
    localparam logic [9:0] LAST_ROW = 10'(IMAGE_HEIGHT - 1);

    state_t      r_state;
    logic [17:0] r_pointer;
    logic [7:0]  r_held_g;
    logic [7:0]  r_held_b;
    logic        r_last_pair;

    logic        w_accept;
    logic        w_last_pixel;

    // Pixel handshake: a pixel transfers on a rising edge where i_pixel_valid
    // and o_pixel_ready are both high; ready depends only on state, never on valid.
    assign o_pixel_ready = (r_state == S_EVEN) || (r_state == S_ODD);
    assign w_accept      = i_pixel_valid && o_pixel_ready;
    assign w_last_pixel  = (o_pixel_col == LAST_COL) && (o_pixel_row == LAST_ROW);
    assign o_state       = r_state;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state           <= S_IDLE;
            r_pointer         <= 18'd0;
            r_held_g          <= 8'd0;
            r_held_b          <= 8'd0;
            r_last_pair       <= 1'b0;
            o_sram_address    <= 18'd0;
            o_sram_write_data <= 16'd0;
            o_sram_we_n       <= 1'b1;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_pixel_col       <= 10'd0;
            o_pixel_row       <= 10'd0;
        end else begin
            o_sram_we_n <= 1'b1;
            o_done      <= 1'b0;

            if (w_accept) begin
                if (o_pixel_col == LAST_COL) begin
                    o_pixel_col <= 10'd0;
                    o_pixel_row <= o_pixel_row + 10'd1;
                end else begin
                    o_pixel_col <= o_pixel_col + 10'd1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pointer   <= i_base_address;
                        o_pixel_col <= 10'd0;
                        o_pixel_row <= 10'd0;
                        o_busy      <= 1'b1;
                        r_state     <= S_EVEN;
                    end
                end
                S_EVEN: begin
                    if (w_accept) begin
                        o_sram_address    <= r_pointer;
                        o_sram_write_data <= i_pixel_data[23:8];
                        o_sram_we_n       <= 1'b0;
                        r_held_b          <= i_pixel_data[7:0];
                        r_pointer         <= r_pointer + 18'd1;
                        r_state           <= S_ODD;
                    end
                end
                S_ODD: begin
                    if (w_accept) begin
                        o_sram_address    <= r_pointer;
                        o_sram_write_data <= {r_held_b, i_pixel_data[23:16]};
                        o_sram_we_n       <= 1'b0;
                        r_held_g          <= i_pixel_data[15:8];
                        r_held_b          <= i_pixel_data[7:0];
                        r_pointer         <= r_pointer + 18'd1;
                        // Counters advance this same edge, so remember now
                        // whether this pair closes the frame.
                        r_last_pair       <= w_last_pixel;
                        r_state           <= S_ODD_2;
                    end
                end
                S_ODD_2: begin
                    o_sram_address    <= r_pointer;
                    o_sram_write_data <= {r_held_g, r_held_b};
                    o_sram_we_n       <= 1'b0;
                    r_pointer         <= r_pointer + 18'd1;
                    if (r_last_pair) begin
                        o_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_EVEN;
                    end
                end
                S_DONE: begin
                    o_busy      <= 1'b0;
                    r_last_pair <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
